// File: rtl/selectio_bitslip_ctrl.sv
// Per-lane word-alignment trainer for a SERDES deserializer: checks each lane against
// a training word, pulses bitslip until it matches, then locks lanes one at a time.
module selectio_bitslip_ctrl #(
  parameter int                 DW        = 4,
  parameter int                 SP_Mult   = 4,
  parameter logic [SP_Mult-1:0] TRAIN_PAT = 4'b0011,
  parameter int                 MATCH_CNT = 8,
  parameter int                 SETTLE    = 4,
  parameter int                 MAX_SLIP  = 7
) (
  input  logic                                 i_fclk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic [DW*SP_Mult-1:0]                i_pardata,
  output logic [DW-1:0]                        o_bitslip,
  output logic [DW-1:0]                        o_lane_locked,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_fail,
  output logic [((DW > 1) ? $clog2(DW) : 1)-1:0] o_lane
);

  localparam int LW = (DW > 1) ? $clog2(DW) : 1;
  localparam int SW = (MAX_SLIP > 0) ? $clog2(MAX_SLIP + 1) : 1;
  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SLIP, S_WAIT, S_DONE, S_FAIL
  } state_t;

  state_t          state, nstate;
  logic [SW-1:0]   slip_cnt;
  logic [MW-1:0]   match_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [SP_Mult-1:0] lane_word;
  logic            lane_match, match_last, last_lane, wait_last, start_ok;
  logic            busy_d, done_d, fail_d;
  logic [DW-1:0]   slip_d;

  // Gather the bits of the lane under training: lane k bit j sits at j*DW+k
  always_comb begin
    lane_word = '0;
    for (int k = 0; k < DW; k++) begin
      for (int j = 0; j < SP_Mult; j++) begin
        if (o_lane == LW'(k)) lane_word[j] = i_pardata[j*DW+k];
      end
    end
  end

  assign lane_match = (lane_word == TRAIN_PAT);
  assign match_last = (match_cnt == MW'(MATCH_CNT - 1));
  assign last_lane  = (o_lane == LW'(DW - 1));
  assign wait_last  = (wait_cnt == WW'(SETTLE - 1));
  assign start_ok   = i_start && (state == S_IDLE || state == S_DONE || state == S_FAIL);

  always_ff @(posedge i_fclk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_fail    <= 1'b0;
      o_bitslip <= '0;
    end else begin
      state     <= nstate;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_fail    <= fail_d;
      o_bitslip <= slip_d;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE, S_DONE, S_FAIL: if (i_start) nstate = S_CHECK;
      S_CHECK: begin
        if (lane_match) begin
          if (match_last && last_lane) nstate = S_DONE;
        end else if (slip_cnt == SW'(MAX_SLIP)) begin
          nstate = S_FAIL;
        end else begin
          nstate = S_SLIP;
        end
      end
      S_SLIP:  nstate = S_WAIT;
      S_WAIT:  if (wait_last) nstate = S_CHECK;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    fail_d = 1'b0;
    slip_d = '0;
    case (state)
      S_CHECK, S_WAIT: busy_d = 1'b1;
      S_SLIP: begin
        busy_d = 1'b1;
        for (int k = 0; k < DW; k++) slip_d[k] = (o_lane == LW'(k));
      end
      S_DONE:  done_d = 1'b1;
      S_FAIL:  fail_d = 1'b1;
      default: ;
    endcase
  end

  // Lane pointer, lock flags and the three counters
  always_ff @(posedge i_fclk or posedge i_rst) begin
    if (i_rst) begin
      o_lane        <= '0;
      o_lane_locked <= '0;
      slip_cnt      <= '0;
      match_cnt     <= '0;
      wait_cnt      <= '0;
    end else if (start_ok) begin
      o_lane        <= '0;
      o_lane_locked <= '0;
      slip_cnt      <= '0;
      match_cnt     <= '0;
    end else begin
      case (state)
        S_CHECK: begin
          if (!lane_match) begin
            match_cnt <= '0;
          end else if (match_last) begin
            for (int k = 0; k < DW; k++) begin
              if (o_lane == LW'(k)) o_lane_locked[k] <= 1'b1;
            end
            match_cnt <= '0;
            if (!last_lane) begin
              o_lane   <= LW'(o_lane + 1'b1);
              slip_cnt <= '0;
            end
          end else begin
            match_cnt <= MW'(match_cnt + 1'b1);
          end
        end
        S_SLIP: begin
          slip_cnt <= SW'(slip_cnt + 1'b1);
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt  <= WW'(wait_cnt + 1'b1);
          match_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_selectio_bitslip_ctrl.sv
// Bench for selectio_bitslip_ctrl: a lane model with rotating training words and an
// event scoreboard of expected output transitions, timed from the i_start edge.
module tb_selectio_bitslip_ctrl;

  localparam int DW  = 4;
  localparam int SPM = 4;
  localparam logic [SPM-1:0] TP = 4'b0011;

  logic              clk = 1'b0;
  logic              i_rst, i_start;
  logic [DW*SPM-1:0] pardata;
  logic [DW-1:0]     o_bitslip, o_lane_locked;
  logic              o_busy, o_done, o_fail;
  logic [1:0]        o_lane;

  selectio_bitslip_ctrl #(
    .DW(DW), .SP_Mult(SPM), .TRAIN_PAT(TP),
    .MATCH_CNT(8), .SETTLE(4), .MAX_SLIP(7)
  ) dut (
    .i_fclk(clk), .i_rst(i_rst), .i_start(i_start), .i_pardata(pardata),
    .o_bitslip(o_bitslip), .o_lane_locked(o_lane_locked), .o_busy(o_busy),
    .o_done(o_done), .o_fail(o_fail), .o_lane(o_lane)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int base = 0;
  int rel;
  logic mon_en = 1'b0;
  logic [31:0] sb_q[$];

  int init_off [DW] = '{default: 0};
  int slips    [DW] = '{default: 0};
  logic bad    [DW] = '{default: 1'b0};

  logic [DW-1:0] p_locked = '0;
  logic [1:0]    p_lane = '0;
  logic          p_busy = 1'b0, p_done = 1'b0, p_fail = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Lane model: each bitslip pulse removes one bit of rotation from that lane
  always @(posedge clk) begin
    for (int k = 0; k < DW; k++) begin
      if (i_start) slips[k] <= 0;
      else if (o_bitslip[k]) slips[k] <= slips[k] + 1;
    end
  end

  always_comb begin
    logic [SPM-1:0] tp;
    int r;
    tp = TP;
    pardata = '0;
    for (int k = 0; k < DW; k++) begin
      r = init_off[k] - slips[k];
      if (r < 0) r = 0;
      for (int j = 0; j < SPM; j++)
        pardata[j*DW+k] = bad[k] ? 1'b0 : tp[(j + r) % SPM];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Event word: {kind, edge relative to i_start sample, value}
  function automatic void exp_ev(input int kind, input int c, input int v);
    sb_q.push_back({kind[7:0], c[15:0], v[7:0]});
  endfunction

  task automatic sb_cmp(input string tag, input int kind, input int r, input logic [7:0] v);
    logic [31:0] got, exp;
    got = {kind[7:0], r[15:0], v};
    exp = (sb_q.size() == 0) ? 32'hFFFF_FFFF : sb_q.pop_front();
    chk(tag, got, exp);
  endtask

  always @(negedge clk) begin
    rel = cyc - base;
    if (mon_en) begin
      if (o_bitslip != '0)         sb_cmp("ev_bitslip", 1, rel, 8'(o_bitslip));
      if (o_lane_locked != p_locked) sb_cmp("ev_locked", 5, rel, 8'(o_lane_locked));
      if (o_lane != p_lane)        sb_cmp("ev_lane", 2, rel, 8'(o_lane));
      if (o_busy && !p_busy)       sb_cmp("ev_busy_rise", 6, rel, 8'd0);
      if (!o_busy && p_busy)       sb_cmp("ev_busy_fall", 7, rel, 8'd0);
      if (o_done && !p_done)       sb_cmp("ev_done_rise", 3, rel, 8'd0);
      if (!o_done && p_done)       sb_cmp("ev_done_fall", 8, rel, 8'd0);
      if (o_fail && !p_fail)       sb_cmp("ev_fail_rise", 4, rel, 8'd0);
      if (!o_fail && p_fail)       sb_cmp("ev_fail_fall", 9, rel, 8'd0);
    end
    p_locked <= o_lane_locked;
    p_lane   <= o_lane;
    p_busy   <= o_busy;
    p_done   <= o_done;
    p_fail   <= o_fail;
  end

  task automatic start_train();
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1 base = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_to(input int rel_end);
    while ((cyc - base) < rel_end) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bitslip"}, 32'(o_bitslip), 32'd0);
    chk({tag, "_locked"},  32'(o_lane_locked), 32'd0);
    chk({tag, "_lane"},    32'(o_lane), 32'd0);
    chk({tag, "_busy"},    32'(o_busy), 32'd0);
    chk({tag, "_done"},    32'(o_done), 32'd0);
    chk({tag, "_fail"},    32'(o_fail), 32'd0);
  endtask

  task automatic exp_hdr_done();
    exp_ev(5, 0, 0); exp_ev(2, 0, 0); exp_ev(6, 1, 0); exp_ev(8, 1, 0);
  endtask

  // All lanes aligned from lane 0: lock every 8 edges, done one edge after the last lock
  task automatic exp_tail(input int t0, input int lane_from);
    int t;
    logic [3:0] lk;
    t = t0;
    lk = (lane_from == 0) ? 4'b0000 : 4'((1 << lane_from) - 1);
    for (int l = lane_from; l < DW; l++) begin
      t = t + 8;
      lk[l] = 1'b1;
      exp_ev(5, t, int'(lk));
      if (l < DW - 1) exp_ev(2, t, l + 1);
    end
    exp_ev(7, t + 1, 0);
    exp_ev(3, t + 1, 0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    #3 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    mon_en = 1'b1;

    // All lanes aligned from reset
    exp_ev(6, 1, 0);
    exp_tail(0, 0);
    start_train();
    run_to(40);
    chk("sb_aligned", 32'(sb_q.size()), 32'd0);
    chk("done_aligned", 32'(o_done), 32'd1);
    chk("locked_aligned", 32'(o_lane_locked), 32'hF);

    // Rerun from DONE, with a stray i_start while checking
    exp_hdr_done();
    exp_tail(0, 0);
    start_train();
    repeat (4) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    run_to(40);
    chk("sb_rerun", 32'(sb_q.size()), 32'd0);

    // Lane 2 two bits off
    init_off[2] = 2;
    exp_hdr_done();
    exp_ev(5, 8, 1);  exp_ev(2, 8, 1);
    exp_ev(5, 16, 3); exp_ev(2, 16, 2);
    exp_ev(1, 18, 4); exp_ev(1, 24, 4);
    exp_tail(28, 2);
    start_train();
    run_to(52);
    chk("sb_slip2", 32'(sb_q.size()), 32'd0);
    chk("done_slip2", 32'(o_done), 32'd1);
    init_off[2] = 0;

    // Lane 1 never matches
    bad[1] = 1'b1;
    exp_hdr_done();
    exp_ev(5, 8, 1); exp_ev(2, 8, 1);
    for (int p = 0; p < 7; p++) exp_ev(1, 10 + 6*p, 2);
    exp_ev(7, 52, 0);
    exp_ev(4, 52, 0);
    start_train();
    run_to(60);
    chk("sb_fail", 32'(sb_q.size()), 32'd0);
    repeat (20) @(negedge clk);
    chk("fail_hold", 32'(o_fail), 32'd1);
    chk("fail_lane", 32'(o_lane), 32'd1);
    chk("fail_locked", 32'(o_lane_locked), 32'h1);
    chk("fail_busy", 32'(o_busy), 32'd0);

    // Restart from FAIL with lane 1 repaired
    bad[1] = 1'b0;
    exp_ev(5, 0, 0); exp_ev(2, 0, 0); exp_ev(6, 1, 0); exp_ev(9, 1, 0);
    exp_tail(0, 0);
    start_train();
    run_to(40);
    chk("sb_restart", 32'(sb_q.size()), 32'd0);

    // Reset while lane 2 is settling after a bitslip
    init_off[2] = 2;
    exp_hdr_done();
    exp_ev(5, 8, 1);  exp_ev(2, 8, 1);
    exp_ev(5, 16, 3); exp_ev(2, 16, 2);
    exp_ev(1, 18, 4);
    start_train();
    run_to(20);
    chk("sb_prereset", 32'(sb_q.size()), 32'd0);
    chk("busy_in_wait", 32'(o_busy), 32'd1);
    mon_en = 1'b0;
    #2 i_rst = 1'b1;
    #1 chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    #1 mon_en = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("idle_bitslip", 32'(o_bitslip), 32'd0);
      chk("idle_busy", 32'(o_busy), 32'd0);
    end

    chk("sb_end", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
